// File: rtl/sdp_nrd_rsp_pkg.sv
// Shared definitions for the SDP N-read MCIF responder: request field layout,
// datapath widths and the issue FSM state type.
package sdp_nrd_rsp_pkg;

  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned SIZE_LSB   = 64;
  localparam int unsigned SIZE_W     = 15;
  localparam int unsigned REQ_PD_W   = SIZE_LSB + SIZE_W;

  localparam int unsigned ATOM_W     = 256;
  localparam int unsigned RSP_PD_W   = 514;
  localparam int unsigned MEM_ADDR_W = 59;

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } nrd_state_e;

endpackage

// File: rtl/sdp_nrd_rsp_obuf.sv
// Two-entry valid/ready response buffer in FIFO order; entry 0 is the head and
// stays stable while the consumer stalls.
module sdp_nrd_rsp_obuf
  import sdp_nrd_rsp_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [RSP_PD_W-1:0] push_pd,
  output logic                pop_valid,
  input  logic                pop_ready,
  output logic [RSP_PD_W-1:0] pop_pd,
  output logic [1:0]          count
);

  logic [RSP_PD_W-1:0] ent0;
  logic [RSP_PD_W-1:0] ent1;
  logic                do_push;
  logic                do_pop;

  assign pop_valid  = (count != 2'd0);
  assign push_ready = (count != 2'd2) || pop_ready;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop_valid && pop_ready;
  assign pop_pd     = ent0;

  // Vacated entries are zeroed so an empty buffer presents an all-zero payload.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= push_pd;
          end else begin
            ent0 <= ent1;
            ent1 <= push_pd;
          end
        end
        2'b01: begin
          ent0  <= ent1;
          ent1  <= '0;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) ent0 <= push_pd;
          else               ent1 <= push_pd;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdp_nrd_mcif_responder.sv
// MCIF-side responder for the SDP N-read client: issues 32B atom reads under
// credit/reservation control and packs atom pairs into 514-bit beats.
// Optional stall counter port enabled by SDP_NRD_RSP_PERF_EN.
module sdp_nrd_mcif_responder
  import sdp_nrd_rsp_pkg::*;
#(
  parameter int unsigned CDT_DEPTH = 8
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  sdp_n2mcif_rd_req_valid,
  output logic                  sdp_n2mcif_rd_req_ready,
  input  logic [REQ_PD_W-1:0]   sdp_n2mcif_rd_req_pd,
  output logic                  mcif2sdp_n_rd_rsp_valid,
  input  logic                  mcif2sdp_n_rd_rsp_ready,
  output logic [RSP_PD_W-1:0]   mcif2sdp_n_rd_rsp_pd,
  input  logic                  sdp_n2mcif_rd_cdt_lat_fifo_pop,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_rd_addr,
  input  logic [ATOM_W-1:0]     mem_rd_data,
`ifdef SDP_NRD_RSP_PERF_EN
  output logic [31:0]           rsp_stall_cnt,
`endif
  output logic                  cdt_err
);

  localparam int unsigned CW = $clog2(CDT_DEPTH + 1);
  localparam logic [CW-1:0] CDT_MAX = CW'(CDT_DEPTH);

  nrd_state_e              state;
  logic [MEM_ADDR_W-1:0]   addr;
  logic [SIZE_W-1:0]       remain;
  logic                    odd;
  logic [CW-1:0]           credits;
  logic [1:0]              open_beats;
  logic [1:0]              occ;
  logic [2:0]              reserved;
  logic                    issue;
  logic                    start;
  logic                    rd_vld_d;
  logic                    rd_odd_d;
  logic                    rd_last_d;
  logic [ATOM_W-1:0]       lo_data;
  logic                    push_valid;
  logic                    push_ready;
  logic                    push_fire;
  logic [RSP_PD_W-1:0]     push_pd;
  logic                    req_addr_unused;

  // Byte offset within an atom is always zero for aligned requests.
  assign req_addr_unused = ^sdp_n2mcif_rd_req_pd[ADDR_LSB +: 5];

  assign reserved    = {1'b0, occ} + {1'b0, open_beats};
  assign issue       = (state == ST_READ) &&
                       (odd || ((reserved < 3'd2) && (credits != '0)));
  assign start       = issue && !odd;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state                   <= ST_IDLE;
      sdp_n2mcif_rd_req_ready <= 1'b1;
      addr                    <= '0;
      remain                  <= '0;
      odd                     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sdp_n2mcif_rd_req_valid) begin
            addr                    <= sdp_n2mcif_rd_req_pd[ADDR_LSB+5 +: MEM_ADDR_W];
            remain                  <= sdp_n2mcif_rd_req_pd[SIZE_LSB +: SIZE_W];
            odd                     <= 1'b0;
            state                   <= ST_READ;
            sdp_n2mcif_rd_req_ready <= 1'b0;
          end
        end
        ST_READ: begin
          if (issue) begin
            addr   <= addr + MEM_ADDR_W'(1);
            odd    <= ~odd;
            remain <= remain - SIZE_W'(1);
            if (remain == '0) begin
              state                   <= ST_IDLE;
              sdp_n2mcif_rd_req_ready <= 1'b1;
            end
          end
        end
        default: begin
          state                   <= ST_IDLE;
          sdp_n2mcif_rd_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Return path: SRAM data arrives one cycle after the strobe.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      rd_vld_d  <= 1'b0;
      rd_odd_d  <= 1'b0;
      rd_last_d <= 1'b0;
      lo_data   <= '0;
    end else begin
      rd_vld_d  <= issue;
      rd_odd_d  <= odd;
      rd_last_d <= (remain == '0);
      if (rd_vld_d && !rd_odd_d && !rd_last_d) lo_data <= mem_rd_data;
    end
  end

  assign push_valid = rd_vld_d && (rd_odd_d || rd_last_d);
  assign push_pd    = rd_odd_d ? {2'b11, mem_rd_data, lo_data}
                               : {2'b01, {ATOM_W{1'b0}}, mem_rd_data};
  assign push_fire  = push_valid && push_ready;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      open_beats <= '0;
    end else begin
      case ({start, push_fire})
        2'b10:   open_beats <= open_beats + 2'd1;
        2'b01:   open_beats <= open_beats - 2'd1;
        default: ;
      endcase
    end
  end

  // A pop at full credit saturates and flags; pop plus beat start cancels out.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      credits <= CDT_MAX;
      cdt_err <= 1'b0;
    end else begin
      if (sdp_n2mcif_rd_cdt_lat_fifo_pop && (credits == CDT_MAX)) cdt_err <= 1'b1;
      if (sdp_n2mcif_rd_cdt_lat_fifo_pop && !start && (credits != CDT_MAX))
        credits <= credits + CW'(1);
      else if (start && !sdp_n2mcif_rd_cdt_lat_fifo_pop)
        credits <= credits - CW'(1);
    end
  end

  sdp_nrd_rsp_obuf u_obuf (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_pd        (push_pd),
    .pop_valid      (mcif2sdp_n_rd_rsp_valid),
    .pop_ready      (mcif2sdp_n_rd_rsp_ready),
    .pop_pd         (mcif2sdp_n_rd_rsp_pd),
    .count          (occ)
  );

`ifdef SDP_NRD_RSP_PERF_EN
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      rsp_stall_cnt <= '0;
    end else if (mcif2sdp_n_rd_rsp_valid && !mcif2sdp_n_rd_rsp_ready &&
                 (rsp_stall_cnt != '1)) begin
      rsp_stall_cnt <= rsp_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
